// File: rtl/lzrw1_decomp_sequencer.sv
// Front-end for the LZRW1 decompressor: pulls group headers and items from an upstream
// valid/ready source and issues one item at a time to the core while it reports idle.
module lzrw1_decomp_sequencer #(
  parameter int ITEM_CNT_W = 16,
  parameter int BYTE_CNT_W = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ITEM_CNT_W-1:0] frame_items,
  input  logic [15:0]           s_word,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [15:0]           dec_data,
  output logic                  dec_ctrl,
  output logic                  dec_valid,
  input  logic                  dec_busy,
  input  logic                  dec_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ITEM_CNT_W-1:0] items_done,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic                  err_zero_offset
);

  typedef enum logic [2:0] {
    IDLE, FETCH_HDR, FETCH_ITEM, ISSUE, WAIT_ACK, WAIT_IDLE, ADVANCE, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [15:0]             hdr;
  logic [3:0]              bit_idx;
  logic [ITEM_CNT_W-1:0]   frame_len;
  logic [ITEM_CNT_W-1:0]   items_inc;
  logic                    item_ctrl;
  logic                    zero_copy;

  assign items_inc = items_done + ITEM_CNT_W'(1);
  assign item_ctrl = hdr[bit_idx];
  assign zero_copy = item_ctrl && (s_word[11:0] == 12'd0);

  assign s_ready   = (state == FETCH_HDR) || (state == FETCH_ITEM);
  assign dec_valid = (state == ISSUE) && !dec_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = (frame_items == '0) ? DONE : FETCH_HDR;
      FETCH_HDR:  if (s_valid) state_nxt = FETCH_ITEM;
      FETCH_ITEM: if (s_valid) state_nxt = zero_copy ? ADVANCE : ISSUE;
      ISSUE:      if (!dec_busy) state_nxt = WAIT_ACK;
      // Core raises busy one cycle after the pulse, so this cycle never looks at it.
      WAIT_ACK:   state_nxt = WAIT_IDLE;
      WAIT_IDLE:  if (!dec_busy) state_nxt = ADVANCE;
      ADVANCE: begin
        if (items_inc == frame_len) state_nxt = DONE;
        else if (bit_idx == 4'd15)  state_nxt = FETCH_HDR;
        else                        state_nxt = FETCH_ITEM;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr             <= '0;
      bit_idx         <= '0;
      frame_len       <= '0;
      dec_data        <= '0;
      dec_ctrl        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      items_done      <= '0;
      byte_count      <= '0;
      err_zero_offset <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (busy && dec_out_valid) byte_count <= byte_count + BYTE_CNT_W'(1);
      case (state)
        IDLE: if (start) begin
          frame_len       <= frame_items;
          items_done      <= '0;
          byte_count      <= '0;
          err_zero_offset <= 1'b0;
        end
        FETCH_HDR: if (s_valid) begin
          hdr     <= s_word;
          bit_idx <= '0;
        end
        FETCH_ITEM: if (s_valid) begin
          dec_data <= s_word;
          dec_ctrl <= item_ctrl;
          if (zero_copy) err_zero_offset <= 1'b1;
        end
        ADVANCE: begin
          items_done <= items_inc;
          if ((items_inc != frame_len) && (bit_idx != 4'd15)) bit_idx <= bit_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
